ram_bus_master: RTL and testbench

Bus initiator that drives the single-port synchronous RAM interface (addr, bidirectional data, cs, we, oe) on behalf of a simple command/stream client. It accepts single or burst read/write commands, sequences the RAM control strobes, drives or releases the shared data bus, and returns read data with a ready/valid handshake. It sits between the ALU/datapath control logic and the banked RAM array, and is the only driver of the RAM's control pins.

---
 rtl/ram_bus_master.sv | 147 ++++++++++++++
 tb/tb_ram_bus_master.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_master.sv
// ram_bus_master: bus initiator for a single-port synchronous RAM.
// Accepts single/burst read and write commands from a client, sequences the
// RAM strobes (cs/we/oe), owns the shared data bus only during write beats,
// and hands read data back over a ready/valid handshake.
module ram_bus_master #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // command channel
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    // write-data stream
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    // read-data stream
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  busy,
    // RAM pins
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_BEAT = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_RD_RESP = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    drive_en;

    // State, address/beat counters and captured read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Next-state logic plus strobes, which are purely a function of state and wr_valid.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        rd_valid  = 1'b0;
        rd_last   = 1'b0;
        busy      = 1'b1;
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        ram_oe    = 1'b0;
        drive_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    cnt_d   = cmd_len;
                    state_d = cmd_write ? ST_WR_BEAT : ST_RD_ADDR;
                end
            end

            ST_WR_BEAT: begin
                wr_ready = 1'b1;
                // A missing beat simply stalls: strobes stay low, counters hold.
                if (wr_valid) begin
                    ram_cs   = 1'b1;
                    ram_we   = 1'b1;
                    drive_en = 1'b1;
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - LEN_WIDTH'(1);
                    end
                end
            end

            ST_RD_ADDR: begin
                ram_cs  = 1'b1;
                ram_oe  = 1'b1;
                state_d = ST_RD_DATA;
            end

            ST_RD_DATA: begin
                // The RAM presents the word registered in the previous cycle.
                ram_cs    = 1'b1;
                ram_oe    = 1'b1;
                rd_data_d = ram_data;
                state_d   = ST_RD_RESP;
            end

            ST_RD_RESP: begin
                rd_valid = 1'b1;
                rd_last  = (cnt_q == '0);
                if (rd_ready) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q - LEN_WIDTH'(1);
                        state_d = ST_RD_ADDR;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ram_addr = addr_q;
    assign rd_data  = rd_data_q;
    // Only a live write beat owns the bus; it is released in every other cycle.
    assign ram_data = drive_en ? wr_data : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_bus_master.sv
// Directed testbench for ram_bus_master with a small synchronous RAM model.
`timescale 1ns/1ps
module tb_ram_bus_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  wr_data = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_last;
    logic        busy;
    logic [15:0] ram_addr;
    wire  [7:0]  ram_data;
    logic        ram_cs;
    logic        ram_we;
    logic        ram_oe;

    int total = 0;
    int bad   = 0;
    int we_cnt = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    ram_bus_master #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .LEN_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
    );

    // Synchronous RAM model: registered read, drives the bus while cs&oe&!we.
    logic [7:0] mem [0:65535];
    logic [7:0] ram_q = '0;
    logic       ram_drv;
    assign ram_drv  = ram_cs && ram_oe && !ram_we;
    assign ram_data = ram_drv ? ram_q : 8'bzzzzzzzz;

    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
        if (ram_cs && ram_oe && !ram_we) ram_q <= mem[ram_addr];
    end

    always @(posedge clk) if (ram_cs && ram_we) we_cnt <= we_cnt + 1;
    always @(negedge clk) if (ram_we && ram_oe) overlap <= overlap + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic w, input logic [15:0] a, input logic [3:0] l);
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            step();
            n++;
        end
        chk("cmd_ready_before_accept", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        step();
        cmd_valid = 1'b0;
        $display("txn cmd write=%0d addr=%h len=%0d", w, a, l);
    endtask

    task automatic wr_beat(input logic [15:0] a, input logic [7:0] d, input int stall, input logic last);
        for (int i = 0; i < stall; i++) begin
            wr_valid = 1'b0;
            @(negedge clk);
            chk("wr_stall_cs", ram_cs, 0);
            chk("wr_stall_we", ram_we, 0);
            chk("wr_stall_addr", ram_addr, a);
            chk("wr_stall_ready", wr_ready, 1);
            step();
        end
        wr_valid = 1'b1; wr_data = d;
        @(negedge clk);
        chk("wr_cs", ram_cs, 1);
        chk("wr_we", ram_we, 1);
        chk("wr_oe", ram_oe, 0);
        chk("wr_addr", ram_addr, a);
        chk("wr_data", ram_data, d);
        step();
        wr_valid = 1'b0;
        chk("wr_busy_after", busy, !last);
        chk("wr_cmd_ready_after", cmd_ready, last);
        $display("txn write beat addr=%h data=%h stall=%0d last=%0d", a, d, stall, last);
    endtask

    task automatic rd_beat(input logic [15:0] a, input logic [7:0] d, input logic last,
                           input int stall, input logic poke);
        if (poke) begin
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0000; cmd_len = 4'd0;
        end
        @(negedge clk);
        chk("rda_cs", ram_cs, 1);
        chk("rda_oe", ram_oe, 1);
        chk("rda_we", ram_we, 0);
        chk("rda_addr", ram_addr, a);
        chk("rda_valid", rd_valid, 0);
        if (poke) begin
            chk("busy_cmd_ready", cmd_ready, 0);
            chk("busy_flag", busy, 1);
        end
        step();
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rdd_cs", ram_cs, 1);
        chk("rdd_oe", ram_oe, 1);
        chk("rdd_we", ram_we, 0);
        chk("rdd_valid", rd_valid, 0);
        step();
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("rd_stall_valid", rd_valid, 1);
            chk("rd_stall_data", rd_data, d);
            chk("rd_stall_last", rd_last, last);
            chk("rd_stall_cs", ram_cs, 0);
            step();
        end
        rd_ready = 1'b1;
        @(negedge clk);
        chk("rd_valid", rd_valid, 1);
        chk("rd_data", rd_data, d);
        chk("rd_last", rd_last, last);
        chk("rd_resp_cs", ram_cs, 0);
        step();
        rd_ready = 1'b0;
        chk("rd_busy_after", busy, !last);
        chk("rd_cmd_ready_after", cmd_ready, last);
        $display("txn read beat addr=%h data=%h stall=%0d last=%0d", a, d, stall, last);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        // Reset values
        #2;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_strobes", {ram_cs, ram_we, ram_oe}, 0);
        #10;
        rst_n = 1'b1;
        step();

        // Single write then read
        send_cmd(1'b1, 16'h1234, 4'd0);
        s = we_cnt;
        wr_beat(16'h1234, 8'hA5, 0, 1'b1);
        step();
        chk("single_write_count", we_cnt - s, 1);
        send_cmd(1'b0, 16'h1234, 4'd0);
        rd_beat(16'h1234, 8'hA5, 1'b1, 0, 1'b0);

        // Wrap-around burst, with a command poked while the read is busy
        send_cmd(1'b1, 16'hFFFE, 4'd3);
        wr_beat(16'hFFFE, 8'h11, 0, 1'b0);
        wr_beat(16'hFFFF, 8'h22, 0, 1'b0);
        wr_beat(16'h0000, 8'h33, 0, 1'b0);
        wr_beat(16'h0001, 8'h44, 0, 1'b1);
        step();
        chk("wrap_mem_0000", mem[16'h0000], 8'h33);
        chk("wrap_mem_ffff", mem[16'hFFFF], 8'h22);
        send_cmd(1'b0, 16'hFFFE, 4'd3);
        rd_beat(16'hFFFE, 8'h11, 1'b0, 0, 1'b0);
        rd_beat(16'hFFFF, 8'h22, 1'b0, 0, 1'b1);
        rd_beat(16'h0000, 8'h33, 1'b0, 0, 1'b0);
        rd_beat(16'h0001, 8'h44, 1'b1, 0, 1'b0);
        chk("poke_not_written", mem[16'h0000], 8'h33);

        // Write stall mid-burst
        send_cmd(1'b1, 16'h0200, 4'd2);
        wr_beat(16'h0200, 8'h01, 0, 1'b0);
        wr_beat(16'h0201, 8'h02, 5, 1'b0);
        wr_beat(16'h0202, 8'h03, 0, 1'b1);
        send_cmd(1'b0, 16'h0200, 4'd2);
        rd_beat(16'h0200, 8'h01, 1'b0, 0, 1'b0);
        rd_beat(16'h0201, 8'h02, 1'b0, 0, 1'b0);
        rd_beat(16'h0202, 8'h03, 1'b1, 0, 1'b0);

        // Read backpressure
        send_cmd(1'b0, 16'hFFFE, 4'd1);
        rd_beat(16'hFFFE, 8'h11, 1'b0, 4, 1'b0);
        rd_beat(16'hFFFF, 8'h22, 1'b1, 0, 1'b0);

        // Reset during RD_DATA
        send_cmd(1'b0, 16'h1234, 4'd0);
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_cs", ram_cs, 0);
        chk("arst_oe", ram_oe, 0);
        chk("arst_we", ram_we, 0);
        chk("arst_rd_valid", rd_valid, 0);
        chk("arst_busy", busy, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_rd_valid", rd_valid, 0);
        send_cmd(1'b1, 16'h0010, 4'd0);
        wr_beat(16'h0010, 8'h5A, 0, 1'b1);
        send_cmd(1'b0, 16'h0010, 4'd0);
        rd_beat(16'h0010, 8'h5A, 1'b1, 0, 1'b0);

        chk("we_oe_overlap", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
